// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: state encodings and default stability length.
package key_debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 4;

    localparam logic [1:0] ENC_LOW      = 2'b00;
    localparam logic [1:0] ENC_CHK_HIGH = 2'b01;
    localparam logic [1:0] ENC_HIGH     = 2'b10;
    localparam logic [1:0] ENC_CHK_LOW  = 2'b11;

    typedef enum logic [1:0] {
        LOW      = ENC_LOW,
        CHK_HIGH = ENC_CHK_HIGH,
        HIGH     = ENC_HIGH,
        CHK_LOW  = ENC_CHK_LOW
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for a single asynchronous bit (two stages by default).
// Shared by every asynchronous input; synchronous active-low reset clears all stages.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge Clock) begin
                    if (!Reset) begin
                        stage_reg[gi] <= 1'b0;
                    end else begin
                        stage_reg[gi] <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge Clock) begin
                    if (!Reset) begin
                        stage_reg[gi] <= 1'b0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Debounces a raw key level into a clean A plus one-cycle rise/fall strobes.
// Optional abort counter (glitch_cnt) is built when DEBOUNCE_GLITCH_CNT_EN is defined.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter  int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       key_in,
    output logic       A,
    output logic       A_rise,
    output logic       A_fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             s;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             a_reg, a_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;

    sync_2ff #(
        .STAGES(2)
    ) u_sync (
        .Clock(Clock),
        .Reset(Reset),
        .d    (key_in),
        .q    (s)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            a_reg     <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    // The counter starts at 1 on entry to a check state: the entering sample counts as the first.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            LOW: begin
                a_next = 1'b0;
                if (s) begin
                    state_next = CHK_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = HIGH;
                    a_next     = 1'b1;
                    rise_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            HIGH: begin
                a_next = 1'b1;
                if (!s) begin
                    state_next = CHK_LOW;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = LOW;
                    a_next     = 1'b0;
                    fall_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = LOW;
                a_next     = 1'b0;
                cnt_next   = '0;
            end
        endcase
    end

    assign A      = a_reg;
    assign A_rise = rise_reg;
    assign A_fall = fall_reg;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       glitch_event;
    logic [7:0] glitch_cnt_reg;

    assign glitch_event = ((state_reg == CHK_HIGH) && !s) ||
                          ((state_reg == CHK_LOW)  &&  s);

    // Saturates so a noisy line cannot wrap the count back to a small value.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            glitch_cnt_reg <= 8'd0;
        end else if (glitch_event && (glitch_cnt_reg != 8'hFF)) begin
            glitch_cnt_reg <= glitch_cnt_reg + 8'd1;
        end
    end

    assign glitch_cnt = glitch_cnt_reg;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected strobes, a monitor checks them.
module tb_key_debounce;

    localparam int SC = 4;

    logic Clock  = 1'b0;
    logic Reset  = 1'b0;
    logic key_in = 1'b0;
    logic A, A_rise, A_fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    key_debounce #(
        .STABLE_CYCLES(SC)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .key_in(key_in),
        .A     (A),
        .A_rise(A_rise),
        .A_fall(A_fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit rise;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];
    exp_t ev;
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    bit   mon_en  = 1'b0;
    bit   a_exp   = 1'b0;

    // cyc holds the number of rising edges seen; read at the falling edge.
    always @(posedge Clock) cyc <= cyc + 1;

    // Monitor: pops an expectation when the DUT strobes or when one falls due.
    always @(negedge Clock) begin
        if (mon_en) begin
            if (A_rise || A_fall || (exp_q.size() > 0 && exp_q[0].edge_no <= cyc)) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL strobe_unexpected: edge %0d got rise=%0b fall=%0b A=%0b, required no strobe",
                             cyc, A_rise, A_fall, A);
                end else begin
                    ev    = exp_q.pop_front();
                    a_exp = ev.rise;
                    if (cyc == ev.edge_no && A_rise === ev.rise && A_fall === !ev.rise && A === ev.rise) begin
                        n_pass++;
                        $display("edge %0d: %s strobe, A=%0b", cyc, ev.rise ? "rise" : "fall", A);
                    end else begin
                        $display("FAIL strobe_%s: got edge %0d rise=%0b fall=%0b A=%0b, required edge %0d",
                                 ev.rise ? "rise" : "fall", cyc, A_rise, A_fall, A, ev.edge_no);
                    end
                end
            end else begin
                n_total++;
                if (A === a_exp) n_pass++;
                else $display("FAIL level: edge %0d got A=%0b, required %0b", cyc, A, a_exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
            $display("edge %0d: %s = %0d", cyc, name, act);
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Returns at the falling edge just before rising edge e, so inputs set now are sampled at e.
    task automatic wait_to(input int e);
        while (cyc < e - 1) @(negedge Clock);
    endtask

    task automatic push_exp(input bit r, input int e);
        exp_t x;
        x.rise    = r;
        x.edge_no = e;
        exp_q.push_back(x);
    endtask

    initial begin
        Reset  = 1'b0;
        key_in = 1'b0;
        wait_to(4);
        check("reset_A", 32'(A), 0);
        check("reset_A_rise", 32'(A_rise), 0);
        check("reset_A_fall", 32'(A_fall), 0);
        check("reset_state", 32'(dut.state_reg), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("reset_glitch_cnt", 32'(glitch_cnt), 0);
`endif
        Reset  = 1'b1;
        mon_en = 1'b1;

        // Clean press and release
        wait_to(10); key_in = 1'b1; push_exp(1'b1, 16);
        wait_to(40); key_in = 1'b0; push_exp(1'b0, 46);

        // Bounce: 3 high, 2 low, then held high from edge 65
        wait_to(60); key_in = 1'b1;
        wait_to(63); key_in = 1'b0;
        wait_to(65); key_in = 1'b1; push_exp(1'b1, 71);
        wait_to(85);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_after_bounce", 32'(glitch_cnt), 1);
`endif
        wait_to(90); key_in = 1'b0; push_exp(1'b0, 96);

        // Threshold pulses: 4 cycles rejected, 5 cycles accepted
        wait_to(120); key_in = 1'b1;
        wait_to(124); key_in = 1'b0;
        wait_to(145);
        check("pulse4_A", 32'(A), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_after_pulse4", 32'(glitch_cnt), 2);
`endif
        wait_to(150); key_in = 1'b1; push_exp(1'b1, 156);
        wait_to(155); key_in = 1'b0; push_exp(1'b0, 161);

        // Reset in the middle of a count
        wait_to(200); key_in = 1'b1;
        wait_to(205);
        check("midcount_state", 32'(dut.state_reg), 1);
        check("midcount_cnt", 32'(dut.cnt_reg), 3);
        Reset = 1'b0;
        wait_to(206);
        check("after_reset_A", 32'(A), 0);
        check("after_reset_state", 32'(dut.state_reg), 0);
        check("after_reset_cnt", 32'(dut.cnt_reg), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("after_reset_glitch", 32'(glitch_cnt), 0);
`endif
        Reset = 1'b1; push_exp(1'b1, 212);
        wait_to(230); key_in = 1'b0; push_exp(1'b0, 236);

        // 300 two-cycle glitches: A must hold, counter saturates
        for (int i = 0; i < 300; i++) begin
            wait_to(250 + 4 * i);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (i == 11) check("glitch_after_10", 32'(glitch_cnt), 10);
`endif
            key_in = 1'b1;
            wait_to(252 + 4 * i);
            key_in = 1'b0;
        end
        wait_to(1470);
        check("glitch_A_held", 32'(A), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_saturated", 32'(glitch_cnt), 255);
`endif

        wait_to(1480);
        check("pending_expectations", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got edge %0d, required finish by edge 1480", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-conditioning stage that drives the A input of the Idle/Start/Stop/Clear control FSM.
- Samples a raw, bouncy, asynchronous push-button/sensor level and synchronises it into the Clock domain.
- Accepts a new level only after it has been stable for a programmable number of cycles.
- Outputs a clean level A plus single-cycle rise/fall strobes, so the downstream FSM never sees glitches or metastable values.

Parameters:
- STABLE_CYCLES, 4, number of extra consecutive synchronised samples (beyond the first) required to accept a new level; legal range is 1 or more.
- CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter; derived, not overridden.

Ports:
- Clock, input, 1, system clock; all logic on the rising edge.
- Reset, input, 1, synchronous, active-low reset.
- key_in, input, 1, raw asynchronous level; may bounce.
- A, output, 1, debounced level; feeds the downstream FSM's A.
- A_rise, output, 1, one-cycle strobe in the cycle A goes 0->1.
- A_fall, output, 1, one-cycle strobe in the cycle A goes 1->0.
- glitch_cnt, output, 8, aborted-transition count; present only with DEBOUNCE_GLITCH_CNT_EN.

Behaviour:
- Reset (Reset==0 at a rising edge) clears everything:
  - Both sync flops, cnt, A, A_rise and A_fall go to 0, glitch_cnt goes to 0, state goes to LOW.
  - Reset has priority over all other activity, including a count in progress.
  - Debouncing restarts from LOW after reset.
- Synchroniser: two flops, key_in -> s1 -> s. The FSM uses only s. A raw edge first sampled at edge k gives s = new value from edge k+1.
- States, 2-bit encoding: LOW=00, CHK_HIGH=01, HIGH=10, CHK_LOW=11.
- LOW:
  - A=0.
  - If s==1: go to CHK_HIGH, cnt<=1.
  - Otherwise stay in LOW, cnt<=0.
- CHK_HIGH:
  - A holds 0.
  - If s==0: abort to LOW, cnt<=0, record a glitch.
  - Else if cnt==STABLE_CYCLES: go to HIGH, A<=1, A_rise<=1, cnt<=0.
  - Else cnt<=cnt+1.
- HIGH:
  - A=1.
  - If s==0: go to CHK_LOW, cnt<=1.
- CHK_LOW:
  - A holds 1.
  - If s==1: abort to HIGH, cnt<=0, record a glitch.
  - Else if cnt==STABLE_CYCLES: go to LOW, A<=0, A_fall<=1, cnt<=0.
  - Else cnt<=cnt+1.
- Strobes: A_rise and A_fall are registered, high for exactly one cycle, never both high in the same cycle. Default value is 0 every cycle.
- Latency: A changes STABLE_CYCLES+2 edges after the edge at which key_in is first sampled at the new value, provided key_in stays stable throughout.
- Pulse filtering:
  - A raw pulse of STABLE_CYCLES cycles or less never changes A.
  - A raw pulse of STABLE_CYCLES+1 cycles or more is always accepted.
- Held level: while a level is held, A stays constant with no repeated strobes.
- Illegal state: none is reachable, but the default branch forces LOW with A=0 and cnt=0.
- A, A_rise and A_fall are direct register outputs, with no combinational path from key_in.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- When defined:
  - glitch_cnt port exists: an 8-bit saturating counter.
  - Increments by 1 on every abort (CHK_HIGH->LOW or CHK_LOW->HIGH).
  - Saturates at 255; cleared only by reset.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package: state encodings LOW/CHK_HIGH/HIGH/CHK_LOW as 2-bit localparams, and the default STABLE_CYCLES.
- Sub-module: sync_2ff, a 1-bit two-flop synchroniser with the same synchronous active-low Reset. It is reused for other asynchronous inputs in the design.
- The FSM, counter and strobes stay in key_debounce.

Test Plan:
- Clean press, STABLE_CYCLES=4: key_in 0->1 sampled at edge 10 and held -> A=1 and A_rise=1 after edge 16; A_rise=0 after edge 17; A remains 1.
- Bounce: key_in high for 3 cycles, low for 2, then high and held, first high at edge 10 -> no A change during the bounce; A rises 6 edges after the final rising sample. glitch_cnt=1 when the macro is on.
- Clean release: from A=1, key_in 1->0 at edge 40 and held -> A=0 and A_fall=1 after edge 46; A_rise stays 0 throughout.
- Threshold pulses, sent separately from A=0: a 4-cycle high pulse leaves A=0 forever; a 5-cycle high pulse gives A=1 for exactly 5 cycles, with one A_rise and one A_fall.
- Reset mid-count: Reset=0 while in CHK_HIGH with cnt=3, key_in held high -> after the reset edge, A=0, cnt=0, state LOW; after Reset=1 at edge r, A rises at edge r+6 (sync refill plus full count).
- Saturation, macro on: 300 alternating 2-cycle glitches -> glitch_cnt stops at 255, and A never changes.
